// File: rtl/if_prefetch.sv
// Instruction prefetch unit: issues sequential word fetches on a req/gnt/rvalid
// bus, buffers returned words with their PCs in a small FIFO and presents the
// FIFO head to IF/ID over valid/ready. flush_i redirects fetch and discards
// every buffered and in-flight instruction.
module if_prefetch #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush_i,
   input  logic [31:0]                flush_pc_i,
   output logic                       mem_req_o,
   output logic [31:0]                mem_addr_o,
   input  logic                       mem_gnt_i,
   input  logic                       mem_rvalid_i,
   input  logic [31:0]                mem_rdata_i,
   output logic                       inst_valid_o,
   output logic [31:0]                inst_o,
   output logic [31:0]                inst_pc_o,
   input  logic                       inst_ready_i,
   output logic [$clog2(DEPTH+1)-1:0] fifo_cnt_o
);

   localparam int CW = $clog2(DEPTH + 1);  // occupancy / counter width
   localparam int PW = $clog2(DEPTH);      // FIFO pointer width
   localparam int SW = CW + 2;             // headroom for summing three counters

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   resp_pc_q, resp_pc_d;
   logic [CW-1:0] live_q, live_d;
   logic [CW-1:0] drop_q, drop_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [31:0]   fifo_pc_q   [DEPTH];
   logic [31:0]   fifo_inst_q [DEPTH];

   logic [SW-1:0] occupancy;
   logic          req;
   logic          grant;
   logic          push;
   logic          pop;

   // Buffered words plus every outstanding request must fit in the FIFO, so a
   // response always finds a free slot. Flush and reset both withdraw the request.
   assign occupancy = SW'(cnt_q) + SW'(live_q) + SW'(drop_q);
   assign req       = !rst && !flush_i && (occupancy < SW'(DEPTH));
   assign grant     = req && mem_gnt_i;
   // Responses for requests issued before a flush are the oldest ones and are
   // consumed from the drop counter first.
   assign push      = mem_rvalid_i && (drop_q == '0) && !flush_i;
   assign pop       = (cnt_q != '0) && inst_ready_i && !flush_i;

   // Next-state for fetch/response PCs, request counters and FIFO bookkeeping.
   always_comb begin
      // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      live_d     = live_q;
      drop_d     = drop_q;
      cnt_d      = cnt_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      if (flush_i) begin
         fetch_pc_d = flush_pc_i & ~32'h3;
         resp_pc_d  = flush_pc_i & ~32'h3;
         // Everything still outstanding becomes stale; a response this cycle retires one.
         drop_d     = CW'(SW'(drop_q) + SW'(live_q) + SW'(grant) - SW'(mem_rvalid_i));
         live_d     = '0;
         cnt_d      = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
      end else begin
         if (grant) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         live_d = live_q + CW'(grant) - CW'(push);
         drop_d = drop_q - CW'(mem_rvalid_i && (drop_q != '0));
         if (push) begin
            resp_pc_d = resp_pc_q + 32'd4;
            wr_ptr_d  = wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         cnt_d = cnt_q + CW'(push) - CW'(pop);
      end
   end

   // Control state register with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         live_q     <= '0;
         drop_q     <= '0;
         cnt_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         live_q     <= live_d;
         drop_q     <= drop_d;
         cnt_q      <= cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   // FIFO storage write port.
   always_ff @(posedge clk) begin
      // NOTE: storage is not reset; the head is only observed while cnt_q != 0.
      if (push) begin
         fifo_pc_q[wr_ptr_q]   <= resp_pc_q;
         fifo_inst_q[wr_ptr_q] <= mem_rdata_i;
      end
   end

   assign mem_req_o    = req;
   assign mem_addr_o   = fetch_pc_q;
   assign inst_valid_o = (cnt_q != '0);
   assign inst_o       = inst_valid_o ? fifo_inst_q[rd_ptr_q] : 32'h0;
   assign inst_pc_o    = inst_valid_o ? fifo_pc_q[rd_ptr_q]   : 32'h0;
   assign fifo_cnt_o   = cnt_q;

   // The issue cap must keep a free slot for every response.
   a_no_push_when_full : assert property (@(posedge clk) disable iff (rst)
      !(push && (cnt_q == CW'(DEPTH))));

   // The memory returns exactly one response per granted request.
   a_no_orphan_rvalid : assert property (@(posedge clk) disable iff (rst)
      !(mem_rvalid_i && (live_q == '0) && (drop_q == '0)));

endmodule

// File: tb/tb_if_prefetch.sv
// Self-checking bench for if_prefetch: a queue-based reference model of the
// request stream, in-flight fetches and output buffer, a randomised memory
// with in-order variable latency, directed scenarios and a random soak.
module tb_if_prefetch;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          CW       = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush_i;
   logic [31:0]   flush_pc_i;
   logic          mem_req_o;
   logic [31:0]   mem_addr_o;
   logic          mem_gnt_i;
   logic          mem_rvalid_i;
   logic [31:0]   mem_rdata_i;
   logic          inst_valid_o;
   logic [31:0]   inst_o;
   logic [31:0]   inst_pc_o;
   logic          inst_ready_i;
   logic [CW-1:0] fifo_cnt_o;

   always #5 clk = ~clk;

   if_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk          (clk),
      .rst          (rst),
      .flush_i      (flush_i),
      .flush_pc_i   (flush_pc_i),
      .mem_req_o    (mem_req_o),
      .mem_addr_o   (mem_addr_o),
      .mem_gnt_i    (mem_gnt_i),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i),
      .inst_valid_o (inst_valid_o),
      .inst_o       (inst_o),
      .inst_pc_o    (inst_pc_o),
      .inst_ready_i (inst_ready_i),
      .fifo_cnt_o   (fifo_cnt_o)
   );

   // Reference model: fetches in flight (oldest first), buffered instructions,
   // and the memory's pending responses.
   typedef struct { logic [31:0] pc; bit stale; } flight_t;
   typedef struct { logic [31:0] pc; logic [31:0] inst; } entry_t;
   typedef struct { logic [31:0] addr; int due; } mresp_t;

   flight_t     inflight[$];
   entry_t      fq[$];
   mresp_t      mq[$];
   logic [31:0] m_fetch_pc;
   int          cyc;
   int          last_due;

   int n_checks;
   int n_fail;

   // Stimulus knobs.
   int          gnt_pct, ready_pct, flush_pct, lat_min, lat_max;
   bit          force_flush;
   logic [31:0] force_pc;

   // DUT outputs as seen mid-cycle of the most recent step.
   logic          obs_req, obs_valid;
   logic [31:0]   obs_addr, obs_pc, obs_inst;
   logic [CW-1:0] obs_cnt;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC0DE_5EED;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %08h, want %08h", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      inflight.delete();
      fq.delete();
      mq.delete();
      m_fetch_pc = RESET_PC;
      last_due   = 0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req"},   32'(mem_req_o),    32'd0);
      check({tag, "_valid"}, 32'(inst_valid_o), 32'd0);
      check({tag, "_cnt"},   32'(fifo_cnt_o),   32'd0);
      check({tag, "_inst"},  inst_o,            32'd0);
      check({tag, "_pc"},    inst_pc_o,         32'd0);
      check({tag, "_addr"},  mem_addr_o,        RESET_PC);
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      flush_i      = 1'b0;
      flush_pc_i   = 32'h0;
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = 32'h0;
      inst_ready_i = 1'b0;
      force_flush  = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;
   endtask

   // Compare every DUT output against the model for the current cycle.
   task automatic compare();
      bit exp_req;
      exp_req   = !flush_i && ((fq.size() + inflight.size()) < DEPTH);
      obs_req   = mem_req_o;
      obs_addr  = mem_addr_o;
      obs_valid = inst_valid_o;
      obs_pc    = inst_pc_o;
      obs_inst  = inst_o;
      obs_cnt   = fifo_cnt_o;
      check("mem_req",    32'(mem_req_o),    32'(exp_req));
      check("mem_addr",   mem_addr_o,        m_fetch_pc);
      check("inst_valid", 32'(inst_valid_o), 32'(fq.size() != 0));
      check("fifo_cnt",   32'(fifo_cnt_o),   32'(fq.size()));
      if (fq.size() != 0) begin
         check("inst_pc", inst_pc_o, fq[0].pc);
         check("inst",    inst_o,    fq[0].inst);
      end
   endtask

   // Advance the model across one clock edge using this cycle's inputs.
   task automatic model_update();
      bit     req, grant, do_pop;
      int     due;
      mresp_t r;
      flight_t f;
      req    = !flush_i && ((fq.size() + inflight.size()) < DEPTH);
      grant  = req && mem_gnt_i;
      do_pop = !flush_i && (fq.size() != 0) && inst_ready_i;
      if (do_pop) void'(fq.pop_front());
      if (mem_rvalid_i) begin
         r = mq.pop_front();
         f = inflight.pop_front();
         if (!flush_i && !f.stale) fq.push_back('{f.pc, mem_rdata_i});
      end
      if (flush_i) begin
         fq.delete();
         foreach (inflight[i]) inflight[i].stale = 1'b1;
         m_fetch_pc = flush_pc_i & ~32'h3;
      end
      if (grant) begin
         inflight.push_back('{m_fetch_pc, 1'b0});
         due = cyc + $urandom_range(lat_max, lat_min);
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         mq.push_back('{m_fetch_pc, due});
         m_fetch_pc = m_fetch_pc + 32'd4;
      end
   endtask

   // One clock cycle: drive inputs, compare mid-cycle, update the model at the edge.
   task automatic step();
      bit do_rv;
      mem_gnt_i    = ($urandom_range(99) < gnt_pct);
      inst_ready_i = ($urandom_range(99) < ready_pct);
      if (force_flush) begin
         flush_i    = 1'b1;
         flush_pc_i = force_pc;
      end else begin
         flush_i    = ($urandom_range(99) < flush_pct);
         flush_pc_i = $urandom;
      end
      do_rv        = (mq.size() != 0) && (mq[0].due <= cyc);
      mem_rvalid_i = do_rv;
      mem_rdata_i  = do_rv ? mem_word(mq[0].addr) : $urandom;
      @(negedge clk);
      compare();
      @(posedge clk);
      model_update();
      cyc++;
      #1;
   endtask

   task automatic set_knobs(input int g, input int r, input int f, input int lmin, input int lmax);
      gnt_pct = g; ready_pct = r; flush_pct = f; lat_min = lmin; lat_max = lmax;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bit found;
      int grants;
      n_checks = 0;
      n_fail   = 0;
      cyc      = 0;
      set_knobs(100, 100, 0, 1, 1);

      // Streaming after reset: addresses 0,4,8 and PCs 0,4,8 back to back.
      do_reset();
      for (int k = 0; k < 6; k++) begin
         step();
         if (k == 0) check("t1_first_req", 32'(obs_req), 32'd1);
         if (k < 3) check("t1_addr", obs_addr, 32'(4 * k));
         if (k >= 2 && k < 5) begin
            check("t1_valid", 32'(obs_valid), 32'd1);
            check("t1_pc", obs_pc, 32'(4 * (k - 2)));
         end
      end

      // Back-pressure: cap stops at DEPTH grants, drains in PC order, resumes.
      do_reset();
      set_knobs(100, 0, 0, 1, 1);
      grants = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (obs_req && mem_gnt_i) grants++;
      end
      check("t2_grants", 32'(grants), 32'(DEPTH));
      check("t2_req_off", 32'(obs_req), 32'd0);
      check("t2_cnt_full", 32'(obs_cnt), 32'(DEPTH));
      set_knobs(100, 100, 0, 1, 1);
      for (int k = 0; k < 4; k++) begin
         step();
         check("t2_pop_pc", obs_pc, 32'(4 * k));
         if (k == 1) check("t2_resume", 32'(obs_req), 32'd1);
      end

      // Flush with three slow responses in flight: all discarded, restart at 0x100.
      do_reset();
      set_knobs(100, 100, 0, 4, 4);
      repeat (3) step();
      set_knobs(0, 100, 0, 4, 4);
      force_flush = 1'b1;
      force_pc    = 32'h0000_0103;
      step();
      check("t3_flush_req", 32'(obs_req), 32'd0);
      force_flush = 1'b0;
      set_knobs(100, 100, 0, 4, 4);
      step();
      check("t3_new_addr", obs_addr, 32'h0000_0100);
      check("t3_new_req", 32'(obs_req), 32'd1);
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         step();
         if (obs_valid) begin
            found = 1'b1;
            check("t3_first_pc", obs_pc, 32'h0000_0100);
         end
      end
      if (!found) check("t3_first_valid_timeout", 32'd0, 32'd1);

      // Flush coinciding with gnt and rvalid: buffer empties, nothing stale shows.
      do_reset();
      set_knobs(100, 0, 0, 1, 1);
      repeat (2) step();
      force_flush = 1'b1;
      force_pc    = 32'h0000_0040;
      step();
      check("t4_flush_req", 32'(obs_req), 32'd0);
      force_flush = 1'b0;
      set_knobs(100, 100, 0, 1, 1);
      step();
      check("t4_cnt_zero", 32'(obs_cnt), 32'd0);
      check("t4_valid_zero", 32'(obs_valid), 32'd0);
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         step();
         if (obs_valid) begin
            found = 1'b1;
            check("t4_first_pc", obs_pc, 32'h0000_0040);
         end
      end
      if (!found) check("t4_first_valid_timeout", 32'd0, 32'd1);

      // Grant stall: request and address hold; a flush withdraws and retargets.
      do_reset();
      set_knobs(0, 100, 0, 1, 1);
      for (int k = 0; k < 5; k++) begin
         step();
         check("t5_stall_req", 32'(obs_req), 32'd1);
         check("t5_stall_addr", obs_addr, RESET_PC);
      end
      force_flush = 1'b1;
      force_pc    = 32'h0000_0200;
      step();
      check("t5_flush_req", 32'(obs_req), 32'd0);
      force_flush = 1'b0;
      step();
      check("t5_retarget_req", 32'(obs_req), 32'd1);
      check("t5_retarget_addr", obs_addr, 32'h0000_0200);
      set_knobs(100, 100, 0, 1, 2);
      repeat (8) step();

      // Address wrap at the top of memory, then an asynchronous reset mid-burst.
      do_reset();
      set_knobs(100, 100, 0, 1, 1);
      force_flush = 1'b1;
      force_pc    = 32'hFFFF_FFF8;
      step();
      force_flush = 1'b0;
      step();
      check("t6_addr0", obs_addr, 32'hFFFF_FFF8);
      step();
      check("t6_addr1", obs_addr, 32'hFFFF_FFFC);
      step();
      check("t6_addr2", obs_addr, 32'h0000_0000);
      set_knobs(100, 0, 0, 1, 1);
      repeat (4) step();
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_reset_outputs("t6_async");
      do_reset();

      // Random soak with varying bus behaviour and occasional flushes.
      for (int blk = 0; blk < 15; blk++) begin
         set_knobs($urandom_range(100, 20), $urandom_range(100, 10),
                   $urandom_range(8, 0), 1, 1);
         lat_min = $urandom_range(2, 1);
         lat_max = lat_min + $urandom_range(4, 0);
         repeat (200) step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
